// File: rtl/mole_game_ctrl.sv
// Multi-target reaction game: lights one pseudo-random target per round and
// scores synchronised, edge-detected active-low button presses against it.
module mole_game_ctrl #(
  parameter int          N_MOLES    = 4,
  parameter int          UP_CYCLES  = 50000000,
  parameter int          GAP_CYCLES = 25000000,
  parameter int          ROUNDS     = 16,
  parameter int          SCORE_W    = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N_MOLES-1:0]           hit_n,
  output logic [N_MOLES-1:0]           mole,
  output logic [SCORE_W-1:0]           hits,
  output logic [SCORE_W-1:0]           misses,
  output logic [$clog2(ROUNDS+1)-1:0]  round_idx,
  output logic                         busy,
  output logic                         game_over,
  output logic                         hit_pulse,
  output logic                         miss_pulse
);

  localparam int          IW   = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
  localparam int          RW   = $clog2(ROUNDS + 1);
  localparam int          MAXC = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int          TW   = $clog2(MAXC + 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting)
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [N_MOLES-1:0] ONE = N_MOLES'(1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_DONE} state_t;

  state_t               state, state_n;
  logic [N_MOLES-1:0]   sync1, sync2, prev, press;
  logic [15:0]          lfsr, lfsr_n;
  logic [TW-1:0]        timer, timer_n;
  logic [IW-1:0]        last_idx, last_idx_n, cand, pick;
  logic [N_MOLES-1:0]   mole_n;
  logic [SCORE_W-1:0]   hits_n, misses_n;
  logic [RW-1:0]        round_n;
  logic                 hit_pulse_n, miss_pulse_n;

  // Buttons idle high, so the synchroniser resets released to avoid a phantom press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= hit_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press  = prev & ~sync2;
  assign lfsr_n = (state == S_IDLE) ? lfsr
                                    : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000));
  assign cand   = IW'(lfsr % 16'(N_MOLES));
  // Bump a repeated candidate to the next target so no target lights twice in a row
  assign pick   = (cand != last_idx)           ? cand :
                  (cand == IW'(N_MOLES - 1))   ? '0   : cand + 1'b1;

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    last_idx_n   = last_idx;
    mole_n       = '0;
    hits_n       = hits;
    misses_n     = misses;
    round_n      = round_idx;
    hit_pulse_n  = 1'b0;
    miss_pulse_n = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          hits_n   = '0;
          misses_n = '0;
          round_n  = '0;
          timer_n  = '0;
          state_n  = S_GAP;
        end
      end
      S_GAP: begin
        if (timer == TW'(GAP_CYCLES - 1)) begin
          last_idx_n = pick;
          mole_n     = ONE << pick;
          timer_n    = '0;
          state_n    = S_UP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_UP: begin
        mole_n = mole;
        // A press on the final lit cycle is checked first, so it beats the timeout
        if (press[last_idx] || (timer == TW'(UP_CYCLES - 1))) begin
          mole_n  = '0;
          timer_n = '0;
          round_n = round_idx + 1'b1;
          if (press[last_idx]) begin
            hits_n      = (&hits) ? hits : hits + 1'b1;
            hit_pulse_n = 1'b1;
          end else begin
            misses_n     = (&misses) ? misses : misses + 1'b1;
            miss_pulse_n = 1'b1;
          end
          state_n = (round_n == RW'(ROUNDS)) ? S_DONE : S_GAP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      timer      <= '0;
      last_idx   <= IW'(N_MOLES - 1);
      mole       <= '0;
      hits       <= '0;
      misses     <= '0;
      round_idx  <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      timer      <= timer_n;
      last_idx   <= last_idx_n;
      mole       <= mole_n;
      hits       <= hits_n;
      misses     <= misses_n;
      round_idx  <= round_n;
      hit_pulse  <= hit_pulse_n;
      miss_pulse <= miss_pulse_n;
      busy       <= (state_n == S_GAP) || (state_n == S_UP);
      game_over  <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: two instances (3-round and 10-round games) checked
// against a round-level model of target choice, timing and scoring.
module tb_mole_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] hit_n;

  logic [3:0] mole_a, mole_b;
  logic [2:0] hits_a, misses_a, hits_b, misses_b;
  logic [1:0] round_a;
  logic [3:0] round_b;
  logic       busy_a, go_a, hp_a, mp_a, busy_b, go_b, hp_b, mp_b;

  mole_game_ctrl #(.N_MOLES(4), .UP_CYCLES(8), .GAP_CYCLES(4), .ROUNDS(3),
                   .SCORE_W(3), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .hit_n(hit_n),
    .mole(mole_a), .hits(hits_a), .misses(misses_a), .round_idx(round_a),
    .busy(busy_a), .game_over(go_a), .hit_pulse(hp_a), .miss_pulse(mp_a)
  );

  mole_game_ctrl #(.N_MOLES(4), .UP_CYCLES(8), .GAP_CYCLES(4), .ROUNDS(10),
                   .SCORE_W(3), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .hit_n(hit_n),
    .mole(mole_b), .hits(hits_b), .misses(misses_b), .round_idx(round_b),
    .busy(busy_b), .game_over(go_b), .hit_pulse(hp_b), .miss_pulse(mp_b)
  );

  always #5 clk = ~clk;

  // Observation mux: the tasks look at whichever instance is in play
  logic       sel;
  logic [3:0] o_mole, o_round;
  logic [2:0] o_hits, o_misses;
  logic       o_busy, o_go, o_hp, o_mp;
  assign o_mole   = sel ? mole_b   : mole_a;
  assign o_round  = sel ? round_b  : {2'b00, round_a};
  assign o_hits   = sel ? hits_b   : hits_a;
  assign o_misses = sel ? misses_b : misses_a;
  assign o_busy   = sel ? busy_b   : busy_a;
  assign o_go     = sel ? go_b     : go_a;
  assign o_hp     = sel ? hp_b     : hp_a;
  assign o_mp     = sel ? mp_b     : mp_a;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_lfsr [2];
  logic [15:0] m_prev [2];
  int          m_last [2];
  bit          m_run  [2];
  logic [3:0]  prev_mole [2];
  int          m_hits, m_misses, m_round, rounds_k, dark_pre;
  logic [3:0]  exp_q[$];
  bit          log_en, replay;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int pick_idx(input logic [15:0] l, input int last);
    int c;
    c = int'(l) % 4;
    if (c == last) c = (c + 1) % 4;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] = 16'hACE1;
      m_prev[i] = 16'hACE1;
      m_last[i] = 3;
      m_run[i] = 1'b0;
      prev_mole[i] = 4'h0;
    end
  endtask

  // The random source runs in every state except the idle one after reset
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = m_lfsr[i];
      if (m_run[i]) m_lfsr[i] = lfsr_step(m_lfsr[i]);
    end
    #1;
  endtask

  task automatic start_game(input int k);
    sel = (k == 1);
    if (k == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    m_run[k] = 1'b1;
    m_hits = 0; m_misses = 0; m_round = 0; dark_pre = 0;
    rounds_k = (k == 1) ? 10 : 3;
    checks++;
    if (o_busy !== 1'b1 || o_go !== 1'b0 || o_hits !== 3'd0 || o_misses !== 3'd0 || o_round !== 4'd0) begin
      failures++;
      $display("FAIL start_clear got busy=%b go=%b hits=%0d misses=%0d round=%0d exp busy=1 go=0 hits=0 misses=0 round=0",
               o_busy, o_go, o_hits, o_misses, o_round);
    end
  endtask

  // wa/pa: lit cycle after the rise at which a wrong/right button is tapped (-1 = none)
  task automatic run_round(input int wa, input int pa, input bit hold, input bit multi, input bit repress);
    int k, dark, lit, idx;
    logic [3:0] exp_m, rm, wm, hm;
    bit exp_hit, exp_done, pulse_bad;
    k = sel ? 1 : 0;
    hm = hold ? 4'hF : 4'h0;
    hit_n = ~hm;
    dark = dark_pre;
    pulse_bad = 1'b0;
    while (o_mole === 4'h0 && dark < 64) begin
      tick();
      dark++;
      if (o_hp !== 1'b0 || o_mp !== 1'b0) pulse_bad = 1'b1;
    end
    checks++;
    if (dark != 4) begin
      failures++;
      $display("FAIL gap_len got=%0d exp=4", dark);
    end
    idx = pick_idx(m_prev[k], m_last[k]);
    m_last[k] = idx;
    exp_m = 4'(1) << idx;
    checks++;
    if (o_mole !== exp_m) begin
      failures++;
      $display("FAIL target got=%b exp=%b", o_mole, exp_m);
    end
    checks++;
    if (o_mole === prev_mole[k]) begin
      failures++;
      $display("FAIL no_repeat got=%b prev=%b exp=different", o_mole, prev_mole[k]);
    end
    prev_mole[k] = o_mole;
    if (log_en) exp_q.push_back(exp_m);
    if (replay && exp_q.size() > 0) begin
      logic [3:0] first_m;
      first_m = exp_q.pop_front();
      checks++;
      if (o_mole !== first_m) begin
        failures++;
        $display("FAIL replay_seq got=%b exp=%b", o_mole, first_m);
      end
    end
    rm = exp_m | (multi ? (4'(1) << ((idx + 2) % 4)) : 4'h0);
    wm = 4'(1) << ((idx + 1) % 4);
    exp_hit = (pa >= 0) && !hold && (pa + 3 <= 8);
    lit = 0;
    while (1) begin
      hit_n = ~(hm | ((lit == wa) ? wm : 4'h0) | ((lit == pa) ? rm : 4'h0));
      tick();
      lit++;
      if (o_mole !== exp_m || lit >= 40) break;
      if (o_hp !== 1'b0 || o_mp !== 1'b0) pulse_bad = 1'b1;
    end
    hit_n = 4'hF;
    checks++;
    if (lit != (exp_hit ? pa + 3 : 8) || o_mole !== 4'h0) begin
      failures++;
      $display("FAIL lit_len got=%0d mole=%b exp=%0d mole=0000", lit, o_mole, exp_hit ? pa + 3 : 8);
    end
    if (exp_hit) begin
      if (m_hits < 7) m_hits++;
    end else begin
      if (m_misses < 7) m_misses++;
    end
    m_round++;
    exp_done = (m_round == rounds_k);
    checks++;
    if (o_hp !== exp_hit || o_mp !== !exp_hit) begin
      failures++;
      $display("FAIL pulse got hp=%b mp=%b exp hp=%b mp=%b", o_hp, o_mp, exp_hit, !exp_hit);
    end
    checks++;
    if (o_hits !== 3'(m_hits) || o_misses !== 3'(m_misses) || o_round !== 4'(m_round)) begin
      failures++;
      $display("FAIL score got hits=%0d misses=%0d round=%0d exp hits=%0d misses=%0d round=%0d",
               o_hits, o_misses, o_round, m_hits, m_misses, m_round);
    end
    checks++;
    if (o_go !== exp_done || o_busy !== !exp_done) begin
      failures++;
      $display("FAIL status got go=%b busy=%b exp go=%b busy=%b", o_go, o_busy, exp_done, !exp_done);
    end
    checks++;
    if (pulse_bad) begin
      failures++;
      $display("FAIL stray_pulse got=1 exp=0");
    end
    dark_pre = 0;
    if (repress) begin
      hit_n = ~rm;
      tick();
      hit_n = 4'hF;
      tick();
      tick();
      dark_pre = 3;
      checks++;
      if (o_hits !== 3'(m_hits) || o_hp !== 1'b0 || o_mole !== 4'h0) begin
        failures++;
        $display("FAIL repress got hits=%0d hp=%b mole=%b exp hits=%0d hp=0 mole=0000",
                 o_hits, o_hp, o_mole, m_hits);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; hit_n = 4'hF; sel = 1'b0;
    model_reset();
    tick();
    tick();
    checks++;
    if ({mole_a, hits_a, misses_a, round_a, busy_a, go_a, hp_a, mp_a,
         mole_b, hits_b, misses_b, round_b, busy_b, go_b, hp_b, mp_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got a_mole=%b a_busy=%b b_mole=%b b_busy=%b exp all zero",
               mole_a, busy_a, mole_b, busy_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_miss();
    log_en = 1'b1;
    start_game(0);
    for (int r = 0; r < 3; r++) run_round(-1, -1, 1'b0, 1'b0, 1'b0);
    log_en = 1'b0;
  endtask

  task automatic test_hits();
    start_game(0);
    for (int r = 0; r < 3; r++) run_round(-1, 2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_hold();
    start_game(0);
    run_round(-1, -1, 1'b1, 1'b0, 1'b0);
    run_round(-1, int'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b0);
    run_round(-1, int'($urandom_range(0, 5)), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrong_and_timeout();
    start_game(0);
    run_round(0, 2, 1'b0, 1'b0, 1'b0);
    run_round(-1, 5, 1'b0, 1'b0, 1'b0);
    run_round(-1, 6, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int pa;
    start_game(1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    dark_pre = 1;
    checks++;
    if (o_busy !== 1'b1 || o_round !== 4'd0 || o_mole !== 4'h0) begin
      failures++;
      $display("FAIL start_busy got busy=%b round=%0d mole=%b exp busy=1 round=0 mole=0000",
               o_busy, o_round, o_mole);
    end
    for (int g = 0; g < 2; g++) begin
      if (g == 1) start_game(1);
      for (int r = 0; r < 10; r++) begin
        pa = int'($urandom_range(0, 5));
        run_round((pa > 0) ? int'($urandom_range(0, pa - 1)) : -1, pa, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      checks++;
      if (o_hits !== 3'd7 || o_go !== 1'b1) begin
        failures++;
        $display("FAIL saturate got hits=%0d go=%b exp hits=7 go=1", o_hits, o_go);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    start_game(0);
    run_round(-1, 1, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (o_mole === 4'h0 && guard < 64) begin
      tick();
      guard++;
    end
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_mole !== 4'h0 || o_hits !== 3'd0 || o_misses !== 3'd0 || o_round !== 4'd0 ||
        o_busy !== 1'b0 || o_go !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got mole=%b hits=%0d misses=%0d round=%0d busy=%b go=%b exp all zero",
               o_mole, o_hits, o_misses, o_round, o_busy, o_go);
    end
    tick();
    rst_n = 1'b1;
    tick();
    replay = 1'b1;
    start_game(0);
    for (int r = 0; r < 3; r++) run_round(-1, -1, 1'b0, 1'b0, 1'b0);
    replay = 1'b0;
  endtask

  initial begin
    log_en = 1'b0;
    replay = 1'b0;
    test_reset();
    test_all_miss();
    test_hits();
    test_hold();
    test_wrong_and_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
